fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Y86-64 pipeline F stage plus F and D pipeline registers. Drives the instruction-memory address,
//  splits the 80-bit little-endian fetch word into icode/ifun/rA/rB/valC, and computes valP and predPC.
//  Latches the results into the D register for the decode stage. Handles redirects and the
//  stall/bubble controls issued by the hazard unit.
// PARAMETERS
//  RESET_PC  64'd0  value loaded into F_predPC on reset
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   reset, asynchronous, active-high
//  F_stall_i      in   1   hold F_predPC
//  D_stall_i      in   1   hold D register
//  D_bubble_i     in   1   load NOP bubble into D register
//  M_icode_i      in   4   icode in M stage
//  M_cnd_i        in   1   branch condition in M stage
//  M_valA_i       in   64  fall-through PC of a mispredicted jXX
//  W_icode_i      in   4   icode in W stage
//  W_valM_i       in   64  return address popped by ret
//  imem_rdata_i   in   80  fetch word; bits[7:0] = byte at PC
//  imem_error_i   in   1   fetch address out of range
//  imem_raddr_o   out  64  f_pc, combinational
//  F_predPC_o     out  64  predicted-PC register
//  D_stat_o       out  3   1=AOK 2=HLT 3=ADR 4=INS
//  D_icode_o      out  4
//  D_ifun_o       out  4
//  D_rA_o         out  4   0xF = none
//  D_rB_o         out  4
//  D_valC_o       out  64
//  D_valP_o       out  64
// BEHAVIOUR
//  f_pc select, priority order:
//   - M_icode=7 && !M_cnd: M_valA.
//   - W_icode=9: W_valM.
//   - otherwise: F_predPC.
//  Decode of the fetch word:
//   - imem_error: icode=1 (NOP), ifun=0.
//   - otherwise: icode=rdata[7:4], ifun=rdata[3:0].
//  Field extraction:
//   - need_regids = icode in {2,3,4,5,6,A,B}; rA=rdata[15:12], rB=rdata[11:8], else both 0xF.
//   - need_valC = icode in {3,4,5,7,8}; valC = need_regids ? rdata[79:16] : rdata[71:8], else 0.
//  valP = f_pc + 1 + need_regids + 8*need_valC, computed modulo 2^64 (wraps, no flag).
//  predPC = valC when icode is 7 or 8, else valP.
//  stat:
//   - imem_error: ADR.
//   - icode > 0xB: INS.
//   - icode = 0: HLT.
//   - otherwise: AOK.
//  FSM {RUN, HALT}:
//   - RUN to HALT when a non-AOK stat is latched into D (D not stalled, no bubble).
//   - HALT to RUN when a redirect occurs (mispredict or W_icode=9); the redirected instruction
//     is fetched that same cycle.
//   - In HALT with no redirect: F_predPC holds and D receives a bubble every cycle.
//  F register: on rst_i, F_predPC=RESET_PC and state=RUN. Else holds if F_stall_i or HALT,
//   otherwise loads predPC.
//  D register, evaluated in this order:
//   - rst_i: bubble {AOK, icode 1, ifun 0, rA F, rB F, valC 0, valP 0}.
//   - D_stall_i: hold. Stall wins if asserted together with D_bubble_i.
//   - D_bubble_i: bubble.
//   - otherwise: load fetched fields.
//  Latency: an instruction at f_pc appears on the D_* outputs 1 cycle later.
//  Reset asserted mid-operation clears all state immediately, asynchronously.
// TESTING
//  T1: word 30 F1 01 00.. at PC 0 -> D: icode3 rA F rB1 valC 1 valP 10; predPC 10.
//  T2: 60 35 at PC 32 -> valP 34, valC 0; then A0 8F -> rA8 rB F valP 36.
//  T3: 70 30 00.. at PC 38 -> predPC 0x30. Next cycle M_icode=7, M_cnd=0, M_valA=47 -> f_pc 47.
//  T4: imem_error=1 -> D_stat=3, icode1; FSM HALT, predPC frozen, D bubbles until W_icode=9 redirect.
//  T5: D_stall and D_bubble both high -> D holds. F_stall high -> F_predPC unchanged; rst_i mid-run -> predPC 0.
//  T6: byte C0 -> stat INS; byte 00 -> stat HLT; f_pc=FFFF_FFFF_FFFF_FFFF with NOP -> valP 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage with the F (predicted PC) and D pipeline registers.
// Selects f_pc, decodes the 80-bit fetch word and applies stall/bubble/halt control.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        F_stall_i,
    input  logic        D_stall_i,
    input  logic        D_bubble_i,
    input  logic [3:0]  M_icode_i,
    input  logic        M_cnd_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  W_icode_i,
    input  logic [63:0] W_valM_i,
    input  logic [79:0] imem_rdata_i,
    input  logic        imem_error_i,
    output logic [63:0] imem_raddr_o,
    output logic [63:0] F_predPC_o,
    output logic [2:0]  D_stat_o,
    output logic [3:0]  D_icode_o,
    output logic [3:0]  D_ifun_o,
    output logic [3:0]  D_rA_o,
    output logic [3:0]  D_rB_o,
    output logic [63:0] D_valC_o,
    output logic [63:0] D_valP_o
);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_POPQ  = 4'hB;
    localparam logic [3:0] R_NONE  = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic {StRun, StHalt} state_t;

    state_t state_q, state_d;

    logic [63:0] pred_pc_q;
    logic [2:0]  d_stat_q;
    logic [3:0]  d_icode_q, d_ifun_q, d_ra_q, d_rb_q;
    logic [63:0] d_valc_q, d_valp_q;

    logic        mispredict, ret_redirect, redirect, frozen;
    logic [63:0] f_pc;
    logic [3:0]  f_icode, f_ifun, f_ra, f_rb;
    logic        need_regids, need_valc;
    logic [63:0] f_valc, f_valp, f_pred_pc;
    logic [2:0]  f_stat;
    logic        f_hold, d_load, d_bubble;

    // PC selection: a mispredicted jump outranks a returning ret
    always_comb begin
        mispredict   = (M_icode_i == I_JXX) && !M_cnd_i;
        ret_redirect = (W_icode_i == I_RET);
        redirect     = mispredict || ret_redirect;
        if (mispredict) begin
            f_pc = M_valA_i;
        end else if (ret_redirect) begin
            f_pc = W_valM_i;
        end else begin
            f_pc = pred_pc_q;
        end
    end

    assign imem_raddr_o = f_pc;

    always_comb begin
        if (imem_error_i) begin
            f_icode = I_NOP;
            f_ifun  = 4'h0;
        end else begin
            f_icode = imem_rdata_i[7:4];
            f_ifun  = imem_rdata_i[3:0];
        end

        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (f_icode)
            4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            4'h7, 4'h8: need_valc = 1'b1;
            default: ;
        endcase

        if (need_regids) begin
            f_ra = imem_rdata_i[15:12];
            f_rb = imem_rdata_i[11:8];
        end else begin
            f_ra = R_NONE;
            f_rb = R_NONE;
        end

        if (!need_valc) begin
            f_valc = 64'd0;
        end else if (need_regids) begin
            f_valc = imem_rdata_i[79:16];
        end else begin
            f_valc = imem_rdata_i[71:8];
        end

        f_valp = f_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);

        if ((f_icode == I_JXX) || (f_icode == I_CALL)) begin
            f_pred_pc = f_valc;
        end else begin
            f_pred_pc = f_valp;
        end

        if (imem_error_i) begin
            f_stat = S_ADR;
        end else if (f_icode > I_POPQ) begin
            f_stat = S_INS;
        end else if (f_icode == I_HALT) begin
            f_stat = S_HLT;
        end else begin
            f_stat = S_AOK;
        end
    end

    // A redirect while halted resumes fetching in that very cycle
    always_comb begin
        frozen   = (state_q == StHalt) && !redirect;
        f_hold   = F_stall_i || frozen;
        d_load   = 1'b0;
        d_bubble = 1'b0;
        if (D_stall_i) begin
            d_load   = 1'b0;
            d_bubble = 1'b0;
        end else if (D_bubble_i || frozen) begin
            d_bubble = 1'b1;
        end else begin
            d_load = 1'b1;
        end

        state_d = state_q;
        if (frozen) begin
            state_d = StHalt;
        end else if (d_load && (f_stat != S_AOK)) begin
            state_d = StHalt;
        end else begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StRun;
            pred_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (!f_hold) begin
                pred_pc_q <= f_pred_pc;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_stat_q  <= S_AOK;
            d_icode_q <= I_NOP;
            d_ifun_q  <= 4'h0;
            d_ra_q    <= R_NONE;
            d_rb_q    <= R_NONE;
            d_valc_q  <= 64'd0;
            d_valp_q  <= 64'd0;
        end else if (d_bubble) begin
            d_stat_q  <= S_AOK;
            d_icode_q <= I_NOP;
            d_ifun_q  <= 4'h0;
            d_ra_q    <= R_NONE;
            d_rb_q    <= R_NONE;
            d_valc_q  <= 64'd0;
            d_valp_q  <= 64'd0;
        end else if (d_load) begin
            d_stat_q  <= f_stat;
            d_icode_q <= f_icode;
            d_ifun_q  <= f_ifun;
            d_ra_q    <= f_ra;
            d_rb_q    <= f_rb;
            d_valc_q  <= f_valc;
            d_valp_q  <= f_valp;
        end
    end

    assign F_predPC_o = pred_pc_q;
    assign D_stat_o   = d_stat_q;
    assign D_icode_o  = d_icode_q;
    assign D_ifun_o   = d_ifun_q;
    assign D_rA_o     = d_ra_q;
    assign D_rB_o     = d_rb_q;
    assign D_valC_o   = d_valc_q;
    assign D_valP_o   = d_valp_q;

endmodule
